// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch requester and the data (load/store) requester. Each access is
//   sequenced IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (one ready pulse)
//   -> IDLE. Data wins arbitration unless fetch has been passed over
//   STARVE_LIMIT times in a row while waiting.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request and address (held until if_ready)
//   if_ready/if_rdata fetch completion pulse and fetched word (held)
//   dm_req/dm_we/dm_addr/dm_wdata  data request, 1 = store, address, store data
//   dm_ready/dm_rdata data completion pulse and load data (held)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro interface
//   busy              high whenever the sequencer is not idle
//   grant_dm          owner of the current or last transaction (1 = data)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_dm
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_LATENCY = 4'(MEM_LATENCY);
  localparam logic [3:0] LP_STARVE  = 4'(STARVE_LIMIT);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [3:0]            r_starve_cnt;
  logic                  r_if_ready;
  logic                  r_dm_ready;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_busy;
  logic                  r_grant_dm;

  // Fetch wins when data is not asking, or when fetch has already lost
  // STARVE_LIMIT consecutive arbitrations while waiting.
  logic w_fetch_wins;
  assign w_fetch_wins = if_req && (!dm_req || (r_starve_cnt == LP_STARVE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_starve_cnt <= '0;
      r_if_ready   <= 1'b0;
      r_dm_ready   <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_grant_dm   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            r_state  <= S_ACCESS;
            r_cnt    <= LP_LATENCY;
            r_busy   <= 1'b1;
            r_mem_en <= 1'b1;
            if (w_fetch_wins) begin
              r_grant_dm   <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= if_addr;
              r_mem_wdata  <= '0;
              r_starve_cnt <= '0;
            end else begin
              r_grant_dm  <= 1'b1;
              r_mem_we    <= dm_we;
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
              if (if_req) begin
                if (r_starve_cnt != LP_STARVE) begin
                  r_starve_cnt <= r_starve_cnt + 4'd1;
                end
              end else begin
                r_starve_cnt <= '0;
              end
            end
          end
        end

        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            // Last memory cycle: read data is valid now; stores leave rdata alone.
            if (!r_mem_we) begin
              if (r_grant_dm) begin
                r_dm_rdata <= mem_rdata;
              end else begin
                r_if_rdata <= mem_rdata;
              end
            end
            r_state     <= S_RESP;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= !r_grant_dm;
            r_dm_ready  <= r_grant_dm;
          end
        end

        S_RESP: begin
          // Bubble cycle: requests are not looked at until back in IDLE.
          r_state    <= S_IDLE;
          r_if_ready <= 1'b0;
          r_dm_ready <= 1'b0;
          r_busy     <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign grant_dm  = r_grant_dm;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, multi-cycle memory between the instruction-fetch requester (IF stage) and the data-memory requester (MEM stage load/store).
- Sequences each access through a fixed-latency transaction and returns data with a one-cycle ready pulse.
- Data port has priority; a starvation counter guarantees forward progress for fetch.
- Sits between the PC/IF stage, the EX/MEM stage and the memory macro; ready-low is used by the hazard unit as a stall source.

Parameters:
- ADDR_WIDTH, 16, address width of both requesters and the memory.
- DATA_WIDTH, 16, data width.
- MEM_LATENCY, 2, cycles the memory needs with mem_en held high (legal range 1..15).
- STARVE_LIMIT, 4, consecutive data grants against a waiting fetch before fetch is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_WIDTH  fetched word; valid when if_ready is high, held afterwards.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load; stable while dm_req is high.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_ready  out  1  one-cycle completion pulse for data.
- dm_rdata  out  DATA_WIDTH  load data; valid when dm_ready is high, held afterwards.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high whenever state is not IDLE.
- grant_dm  out  1  owner of the current or last transaction (1 = data, 0 = fetch).

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Every output, starve_cnt and the access counter go to 0. Any in-flight transaction is discarded; no ready pulse is issued for it.
- States: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE. All mem_* outputs are 0.
- IDLE, any request sampled high: arbitrate and latch the owner, address, we and wdata. Load cnt = MEM_LATENCY and go to ACCESS.
- Arbitration applies only in IDLE:
  - winner = fetch if (if_req && (!dm_req || starve_cnt == STARVE_LIMIT)), otherwise data.
  - Fetch grant: starve_cnt is cleared to 0.
  - Data grant with if_req high: starve_cnt increments, saturating at STARVE_LIMIT.
  - Data grant with if_req low: starve_cnt is cleared to 0.
- ACCESS:
  - mem_en = 1. mem_addr and mem_wdata are the latched values. mem_we = latched we (always 0 for fetch).
  - cnt decrements every cycle.
  - In the cycle with cnt == 1: a read captures mem_rdata into the owner's rdata register at the clock edge, then the state goes to RESP.
  - Exactly MEM_LATENCY cycles are spent in ACCESS.
- RESP:
  - mem_en = 0, mem_we = 0.
  - The owner's ready = 1 for exactly one cycle; the other ready stays 0.
  - The next state is always IDLE (one bubble cycle; requests are ignored in RESP).
- Latency: request sampled in IDLE at edge N gives ready high in cycle N + MEM_LATENCY + 1. Back-to-back transactions have a throughput of one access per MEM_LATENCY + 2 cycles.
- Stores: dm_rdata is not modified. dm_ready pulses as for loads.
- A request that arrives during ACCESS or RESP waits; it is arbitrated at the next IDLE.
- Requester protocol:
  - req must stay high until ready. After ready, req high in IDLE is a new transaction.
  - A req that drops before ready does not cancel the transaction in progress.
- if_rdata and dm_rdata are registered and keep their last captured value until the next capture for the same owner.
- grant_dm updates only at grant time and holds otherwise.

Test Plan:
- Reset, then if_req=1, if_addr=0x0010, mem_rdata=0xA5A5 in the last ACCESS cycle, MEM_LATENCY=2 → mem_en high for 2 cycles with mem_addr=0x0010 and mem_we=0; if_ready pulses 3 cycles after the request; if_rdata=0xA5A5; busy low again one cycle later.
- if_req and dm_req both high (dm_we=1, dm_addr=0x0020, dm_wdata=0x1234) → data wins with grant_dm=1, mem_we=1, mem_wdata=0x1234; dm_ready pulses; dm_rdata unchanged; fetch is then served starting at the next IDLE.
- if_req held high and dm_req re-asserted after every dm_ready, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, then the pattern repeats; starve_cnt never exceeds 4.
- Load (dm_we=0, dm_addr=0x0040, mem_rdata=0xBEEF), then a store → dm_rdata=0xBEEF after the load and still 0xBEEF after the store's dm_ready.
- rst driven low mid-ACCESS (cnt=1) → mem_en, busy and both ready outputs go to 0 immediately without waiting for a clock edge; after release with if_req high, a fresh transaction starts with full MEM_LATENCY.
- MEM_LATENCY=1, single fetch → mem_en high for exactly 1 cycle; if_ready 2 cycles after the request; no request is accepted during RESP.
